sysid_reader: RTL and testbench
===============================

SYSID_READER -- requirements
Module: sysid_reader

Interface
REQ-001 Parameter EXPECTED_ID, default 32'd0: system ID value expected at address 0.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 32'd1618194548: timestamp expected at address 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum stalled cycles allowed per read.
REQ-004 Parameter MAX_RETRIES, default 3: read re-attempts allowed after a timeout.
REQ-005 Port clock  in  1: single clock; all logic is rising-edge.
REQ-006 Port reset  in  1: reset, synchronous, active-high.
REQ-007 Port start  in  1: one-cycle pulse that requests a re-check; ignored unless in DONE.
REQ-008 Port avm_address  out  1: Avalon-MM word address (0 = ID, 1 = timestamp).
REQ-009 Port avm_read  out  1: Avalon-MM read strobe.
REQ-010 Port avm_waitrequest  in  1: responder stall; readdata is valid on any cycle where avm_read=1 and avm_waitrequest=0.
REQ-011 Port avm_readdata  in  32: responder read data.
REQ-012 Port done  out  1: check complete; held high in DONE.
REQ-013 Port pass  out  1: both values matched; meaningful only while done=1.
REQ-014 Port fail_code  out  2: 0 = none, 1 = ID mismatch, 2 = timestamp mismatch, 3 = timeout.
REQ-015 Port id_value  out  32: last captured ID word.
REQ-016 Port ts_value  out  32: last captured timestamp word.

Function
REQ-017 The FSM SHALL use states IDLE, RD_ID, RD_TS, EVAL, DONE.
REQ-018 IDLE SHALL go to RD_ID on the next cycle automatically, so one check runs after every reset.
REQ-019 In RD_ID, the block SHALL drive avm_read=1 and avm_address=0, holding both stable while avm_waitrequest=1.
- When avm_waitrequest=0: capture avm_readdata into id_value, deassert avm_read next cycle, go to RD_TS.
REQ-020 RD_TS SHALL behave the same as RD_ID with avm_address=1, capturing into ts_value, then go to EVAL.
REQ-021 At least one idle cycle (avm_read=0) SHALL separate consecutive reads.
- Minimum accepted-read-to-DONE latency: 5 cycles from reset release with zero waitrequest.
REQ-022 EVAL SHALL last one cycle and set fail_code by priority: ID mismatch (1), then timestamp mismatch (2), else 0; pass=(fail_code==0); then go to DONE.
REQ-023 In DONE, a start pulse SHALL clear done, pass and fail_code and go to RD_ID; id_value and ts_value SHALL hold until overwritten.
REQ-024 A per-read stall counter SHALL count cycles with avm_read=1 and avm_waitrequest=1, and clear when each read completes.
REQ-025 When the stall counter reaches TIMEOUT_CYCLES, the block SHALL drop avm_read for one cycle, increment the retry count, and reissue the same address.
REQ-026 When the retry count would exceed MAX_RETRIES, the block SHALL go to DONE with fail_code=3 and pass=0.
- The retry count SHALL reset at the start of each check.
REQ-027 If avm_waitrequest falls on the same cycle the counter reaches TIMEOUT_CYCLES, the data SHALL be accepted (success wins).
REQ-028 The stall counter SHALL be sized as $clog2(TIMEOUT_CYCLES+1) bits and SHALL saturate, never wrap.

Reset
REQ-029 On reset, the block SHALL set state=IDLE, avm_read=0, avm_address=0, done=0, pass=0, fail_code=0, id_value=0, ts_value=0, and clear all counters.
REQ-030 Reset asserted mid-read SHALL drop avm_read on the next edge; no data SHALL be captured on that cycle.

Configuration
REQ-031 With macro SYSID_READER_TIMEOUT_EN defined, the stall counter, retry logic and fail_code=3 SHALL be present.
REQ-032 Without the macro, reads SHALL wait indefinitely on avm_waitrequest, and fail_code SHALL never be 3.
- TIMEOUT_CYCLES and MAX_RETRIES remain declared but unused.

Structure
REQ-033 Package sysid_reader_pkg SHALL hold:
- the state enum;
- fail-code localparams (FAIL_NONE, FAIL_ID, FAIL_TS, FAIL_TIMEOUT);
- the address localparams (ADDR_ID=0, ADDR_TS=1).
REQ-034 Sub-module sysid_reader_timer (stall counter plus retry counter, saturating) SHALL be instantiated only under SYSID_READER_TIMEOUT_EN.

Verification
REQ-035 Zero-wait responder returning 0 and 1618194548: done=1, pass=1, fail_code=0, 5 cycles after reset release.
REQ-036 Responder returning ID 32'h1 and a correct timestamp: done=1, pass=0, fail_code=1, id_value=1.
REQ-037 Responder stalls 3 cycles on each read: avm_address and avm_read stable during the stall, pass=1.
REQ-038 With TIMEOUT_EN, TIMEOUT_CYCLES=8, MAX_RETRIES=2 and permanent waitrequest: exactly 3 read attempts, each separated by one idle cycle, then fail_code=3, pass=0.
REQ-039 Reset asserted during RD_TS stall: avm_read=0 next cycle, then the full sequence reruns and passes.
REQ-040 start pulse in DONE while the responder timestamp is changed to 5: done drops, then rises with fail_code=2, ts_value=5.

Source files
------------

// File: rtl/sysid_reader_pkg.sv
// Shared types and constants for the system-ID reader: FSM states, fail codes,
// Avalon word addresses and the result-classification helper.
package sysid_reader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        RD_TS = 3'd2,
        EVAL  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] FAIL_NONE    = 2'd0;
    localparam logic [1:0] FAIL_ID      = 2'd1;
    localparam logic [1:0] FAIL_TS      = 2'd2;
    localparam logic [1:0] FAIL_TIMEOUT = 2'd3;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // ID mismatch outranks timestamp mismatch.
    function automatic logic [1:0] eval_fail_code(
        input logic [31:0] id_word,
        input logic [31:0] ts_word,
        input logic [31:0] exp_id,
        input logic [31:0] exp_ts
    );
        logic [1:0] code_s;
        if (id_word != exp_id) begin
            code_s = FAIL_ID;
        end else if (ts_word != exp_ts) begin
            code_s = FAIL_TS;
        end else begin
            code_s = FAIL_NONE;
        end
        return code_s;
    endfunction

endpackage

// File: rtl/sysid_reader_timer.sv
// Saturating per-read stall counter and per-check retry counter; used only
// when SYSID_READER_TIMEOUT_EN is defined.
module sysid_reader_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES    = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic stall,
    input  logic accept,
    output logic timeout,
    output logic retry_exhausted
);

    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    logic [STALL_W-1:0] stall_cnt_r;
    logic [RETRY_W-1:0] retry_cnt_r;

    // A stall cycle seen with the counter already at the limit is the timeout;
    // a cycle where waitrequest falls is not a stall, so the data wins.
    assign timeout         = stall && (stall_cnt_r == STALL_LIMIT);
    assign retry_exhausted = (retry_cnt_r >= RETRY_LIMIT);

    // Stall and retry counters, both saturating.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            stall_cnt_r <= {STALL_W{1'b0}};
            retry_cnt_r <= {RETRY_W{1'b0}};
        end else if (accept) begin
            stall_cnt_r <= {STALL_W{1'b0}};
        end else if (timeout) begin
            stall_cnt_r <= {STALL_W{1'b0}};
            if (retry_cnt_r < RETRY_LIMIT) begin
                retry_cnt_r <= retry_cnt_r + {{(RETRY_W-1){1'b0}}, 1'b1};
            end else begin
                retry_cnt_r <= retry_cnt_r;
            end
        end else if (stall && (stall_cnt_r < STALL_LIMIT)) begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: rtl/sysid_reader.sv
// Reads the system ID and timestamp words over Avalon-MM and compares them with
// the expected values. Define SYSID_READER_TIMEOUT_EN to add stall timeout/retry.
module sysid_reader
    import sysid_reader_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1618194548,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_t     state_r;
    logic       accept_s;
    logic       timeout_s;
    logic       retry_exhausted_s;
    logic [1:0] eval_code_s;

    assign accept_s    = avm_read && !avm_waitrequest;
    assign eval_code_s = eval_fail_code(id_value, ts_value, EXPECTED_ID, EXPECTED_TIMESTAMP);

`ifdef SYSID_READER_TIMEOUT_EN
    logic stall_s;
    logic check_start_s;

    assign stall_s       = avm_read && avm_waitrequest;
    assign check_start_s = (state_r == IDLE) || ((state_r == DONE) && start);

    sysid_reader_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) u_timer (
        .clock           (clock),
        .reset           (reset),
        .clear           (check_start_s),
        .stall           (stall_s),
        .accept          (accept_s),
        .timeout         (timeout_s),
        .retry_exhausted (retry_exhausted_s)
    );
`else
    assign timeout_s         = 1'b0;
    assign retry_exhausted_s = 1'b0;
`endif

    // Check sequencer with registered bus and result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            avm_read    <= 1'b0;
            avm_address <= ADDR_ID;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FAIL_NONE;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r     <= RD_ID;
                    avm_read    <= 1'b1;
                    avm_address <= ADDR_ID;
                end
                RD_ID: begin
                    // read=0 here is the idle gap after a timeout; reissue.
                    if (!avm_read) begin
                        avm_read    <= 1'b1;
                        avm_address <= ADDR_ID;
                    end else if (accept_s) begin
                        avm_read <= 1'b0;
                        id_value <= avm_readdata;
                        state_r  <= RD_TS;
                    end else if (timeout_s) begin
                        avm_read <= 1'b0;
                        if (retry_exhausted_s) begin
                            state_r   <= DONE;
                            done      <= 1'b1;
                            pass      <= 1'b0;
                            fail_code <= FAIL_TIMEOUT;
                        end else begin
                            state_r <= RD_ID;
                        end
                    end else begin
                        avm_read <= avm_read;
                    end
                end
                RD_TS: begin
                    // Entered with read=0, which provides the inter-read gap.
                    if (!avm_read) begin
                        avm_read    <= 1'b1;
                        avm_address <= ADDR_TS;
                    end else if (accept_s) begin
                        avm_read <= 1'b0;
                        ts_value <= avm_readdata;
                        state_r  <= EVAL;
                    end else if (timeout_s) begin
                        avm_read <= 1'b0;
                        if (retry_exhausted_s) begin
                            state_r   <= DONE;
                            done      <= 1'b1;
                            pass      <= 1'b0;
                            fail_code <= FAIL_TIMEOUT;
                        end else begin
                            state_r <= RD_TS;
                        end
                    end else begin
                        avm_read <= avm_read;
                    end
                end
                EVAL: begin
                    fail_code <= eval_code_s;
                    pass      <= (eval_code_s == FAIL_NONE);
                    done      <= 1'b1;
                    state_r   <= DONE;
                end
                DONE: begin
                    if (start) begin
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        fail_code   <= FAIL_NONE;
                        avm_read    <= 1'b1;
                        avm_address <= ADDR_ID;
                        state_r     <= RD_ID;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    avm_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_reader.sv
// Directed bench for sysid_reader: a modelled Avalon responder, a scoreboard of
// expected check results, and immediate-assertion comparisons.
module tb_sysid_reader;

    localparam logic [31:0] GOOD_TS = 32'd1618194548;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'hDEAD_BEEF;
    logic        done;
    logic        pass;
    logic [1:0]  fail_code;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    typedef struct {
        logic        pass;
        logic [1:0]  fc;
        logic [31:0] id;
        logic [31:0] ts;
    } result_t;

    result_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Responder knobs
    logic [31:0] id_rsp = 32'd0;
    logic [31:0] ts_rsp = GOOD_TS;
    int          stall_n = 0;
    logic        perm_wait = 1'b0;
    int          rsp_stall = 0;

    // Stability monitor state
    logic stab_en = 1'b0;
    int   stall_seen = 0;
    logic p_read = 1'b0;
    logic p_wait = 1'b0;
    logic p_addr = 1'b0;

    sysid_reader #(
        .EXPECTED_ID        (32'd0),
        .EXPECTED_TIMESTAMP (GOOD_TS),
        .TIMEOUT_CYCLES     (8),
        .MAX_RETRIES        (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .done            (done),
        .pass            (pass),
        .fail_code       (fail_code),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Responder: stalls stall_n cycles per read (or forever), then returns data.
    initial begin
        forever begin
            @(negedge clock);
            if (avm_read) begin
                if (perm_wait) begin
                    avm_waitrequest = 1'b1;
                end else if (rsp_stall < stall_n) begin
                    avm_waitrequest = 1'b1;
                    avm_readdata    = 32'hDEAD_BEEF;
                    rsp_stall++;
                end else begin
                    avm_waitrequest = 1'b0;
                    avm_readdata    = avm_address ? ts_rsp : id_rsp;
                end
            end else begin
                avm_waitrequest = 1'b0;
                avm_readdata    = 32'hDEAD_BEEF;
                rsp_stall       = 0;
            end
        end
    end

    // Bus-hold monitor: a stalled read must keep read and address unchanged.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (stab_en && p_read && p_wait) begin
                stall_seen++;
                check("stall_read_held", {31'd0, avm_read}, 32'd1);
                check("stall_addr_held", {31'd0, avm_address}, {31'd0, p_addr});
            end
            p_read = avm_read;
            p_wait = avm_waitrequest;
            p_addr = avm_address;
        end
    end

    task automatic push_exp(input logic ps, input logic [1:0] fc, input logic [31:0] id, input logic [31:0] ts);
        result_t r;
        r.pass = ps;
        r.fc   = fc;
        r.id   = id;
        r.ts   = ts;
        exp_q.push_back(r);
    endtask

    // Wait (bounded) for done, then pop the scoreboard and compare.
    task automatic wait_done(input string tag, input int budget, output int lat);
        result_t r;
        lat = 0;
        while (!done && lat < budget) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
        end else begin
            r = exp_q.pop_front();
            check({tag, "_pass"}, {31'd0, pass}, {31'd0, r.pass});
            check({tag, "_fail_code"}, {30'd0, fail_code}, {30'd0, r.fc});
            check({tag, "_id_value"}, id_value, r.id);
            check({tag, "_ts_value"}, ts_value, r.ts);
        end
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        int n;
        int attempts;
        int gap;
        logic prev;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_read", {31'd0, avm_read}, 32'd0);
        check("rst_addr", {31'd0, avm_address}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_fail_code", {30'd0, fail_code}, 32'd0);
        check("rst_id", id_value, 32'd0);
        check("rst_ts", ts_value, 32'd0);

        // Zero-wait check after reset: done five cycles after release
        push_exp(1'b1, 2'd0, 32'd0, GOOD_TS);
        reset = 1'b0;
        wait_done("auto", 40, lat);
        check("auto_latency", lat, 32'd5);

        // ID mismatch
        id_rsp = 32'd1;
        push_exp(1'b0, 2'd1, 32'd1, GOOD_TS);
        pulse_start("idbad");
        wait_done("idbad", 40, lat);

        // Three-cycle stall on each read, bus held steady
        id_rsp     = 32'd0;
        stall_n    = 3;
        stall_seen = 0;
        stab_en    = 1'b1;
        push_exp(1'b1, 2'd0, 32'd0, GOOD_TS);
        pulse_start("stall");
        wait_done("stall", 60, lat);
        stab_en = 1'b0;
        check("stall_cycles", stall_seen, 32'd6);

        // Reset during the timestamp stall, then a clean rerun
        push_exp(1'b1, 2'd0, 32'd0, GOOD_TS);
        pulse_start("rstmid");
        n = 0;
        while (!(avm_read && avm_address) && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("rstmid_reached_ts", {31'd0, avm_read & avm_address}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("rstmid_read_drop", {31'd0, avm_read}, 32'd0);
        check("rstmid_id_clear", id_value, 32'd0);
        reset = 1'b0;
        wait_done("rstmid", 60, lat);

        // Timestamp changes to 5 before a re-check
        stall_n = 0;
        ts_rsp  = 32'd5;
        push_exp(1'b0, 2'd2, 32'd0, 32'd5);
        pulse_start("tsbad");
        wait_done("tsbad", 40, lat);

`ifdef SYSID_READER_TIMEOUT_EN
        // Permanent waitrequest: three attempts, one idle cycle apart, then timeout
        perm_wait = 1'b1;
        push_exp(1'b0, 2'd3, 32'd0, 32'd5);
        pulse_start("tmo");
        prev     = 1'b0;
        attempts = 0;
        gap      = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (avm_read && !prev) begin
                attempts++;
                if (attempts > 1) begin
                    check("tmo_gap", gap, 32'd1);
                end
                gap = 0;
            end else if (!avm_read) begin
                gap++;
            end
            prev = avm_read;
            @(negedge clock);
        end
        check("tmo_attempts", attempts, 32'd3);
        wait_done("tmo", 5, lat);
        perm_wait = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
